sram_result_reader: RTL and testbench

Port-A read engine for the two-port result SRAM. Once the CNN accelerator has asserted DONE, it fetches a programmed address range through the SRAM read port (CENA/AA/QA). It streams the words out over a valid/ready interface toward a host or checker, with full backpressure support. This is the consumer end of the SRAM that the accelerator fills through port B.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/sram_rd_skid.sv | 61 ++++++
 rtl/sram_result_reader.sv | 137 +++++++++++++
 tb/tb_sram_result_reader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and types for the result-SRAM read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

    // Mirrors of the accelerator's def.v word and address widths.
    localparam int INTERNAL_BITS  = 32;
    localparam int SRAM_ADDR_BITS = 16;

    // Read-ahead window: words issued to the SRAM but not yet taken by the sink.
    localparam int RD_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } rd_state_e;

endpackage

// File: rtl/sram_rd_skid.sv
// sram_rd_skid: 2-entry registered FIFO holding captured SRAM words plus their last-beat tag.
// Latency: a word pushed at an edge is at the head from the following cycle.
// Backpressure: no overflow guard; the caller's credit logic keeps pushes within depth and pops only when count!=0.
// Ports: push/push_dat/push_last (write), pop (read), count (occupancy), head_dat/head_last (current head).
module sram_rd_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_dat,
    output logic              head_last
);

    logic [1:0][DATA_W-1:0] dat_q, dat_d;
    logic [1:0]             last_q, last_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;

    always_comb begin
        dat_d    = dat_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            dat_d[wr_ptr_q]  = push_dat;
            last_d[wr_ptr_q] = push_last;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dat_q    <= '0;
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            dat_q    <= dat_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign head_dat  = dat_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];

endmodule

// File: rtl/sram_result_reader.sv
// sram_result_reader: port-A read engine streaming a programmed SRAM address range out over valid/ready.
// Latency: start edge E0 -> first CENA low in the next cycle, first out_valid two cycles later; done 1 cycle after the last beat.
// Backpressure: full; at most 2 words are read ahead of the sink, issue stalls when the window is used up.
// Ports: start/base_addr/length (request), busy/done (status), SRAM_CENA/SRAM_AA/SRAM_QA (port A),
//        out_valid/out_ready/out_data/out_last (result stream).
module sram_result_reader
    import cnn_pkg::*;
#(
    parameter int DATA_W = INTERNAL_BITS,
    parameter int ADDR_W = SRAM_ADDR_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              SRAM_CENA,
    output logic [ADDR_W-1:0] SRAM_AA,
    input  logic [DATA_W-1:0] SRAM_QA,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;       // next address to issue
    logic [ADDR_W-1:0] aa_q, aa_d;           // last issued address, held on AA while idle
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] head_dat;
    logic              head_last;
    logic              pop;
    logic              issue;
    logic [2:0]        credit;

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head_dat;
    assign out_last  = out_valid & head_last;
    assign pop       = out_valid & out_ready;

    // Words still owed to the sink after this cycle's pop; a new issue is allowed
    // only if it keeps the read-ahead window within the FIFO depth.
    assign credit = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue  = (state_q == READ) && (issued_q != len_q) && (credit < 3'(RD_FIFO_DEPTH));

    assign SRAM_CENA = ~issue;
    assign SRAM_AA   = issue ? addr_q : aa_q;
    assign busy      = (state_q == READ) || (state_q == DRAIN);
    assign done      = (state_q == FIN);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        aa_d            = aa_q;
        len_d           = len_q;
        issued_d        = issued_q;
        // The SRAM returns data one cycle after an issue; the tag rides with it.
        inflight_d      = issue;
        inflight_last_d = issue && (issued_q == (len_q - (ADDR_W+1)'(1)));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    // An empty range still spends one busy cycle (in DRAIN) so
                    // done lands two cycles after start, like a real run's tail.
                    state_d  = (length == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (issue) begin
                    aa_d     = addr_q;
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + (ADDR_W+1)'(1);
                    if ((issued_q + (ADDR_W+1)'(1)) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((len_q == '0) || (pop && head_last)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            aa_q            <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            aa_q            <= aa_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    sram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_dat  (SRAM_QA),
        .push_last (inflight_last_q),
        .pop       (pop),
        .count     (fifo_count),
        .head_dat  (head_dat),
        .head_last (head_last)
    );

endmodule

// File: tb/tb_sram_result_reader.sv
// tb_sram_result_reader: directed bench for sram_result_reader with a queue-based reference model.
// Latency: n/a.
// Backpressure: out_ready driven either constantly high or pseudo-randomly per cycle.
module tb_sram_result_reader;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic          SRAM_CENA;
    logic [AW-1:0] SRAM_AA;
    logic [DW-1:0] SRAM_QA = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;

    always #5 clk = ~clk;

    sram_result_reader #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .SRAM_CENA (SRAM_CENA),
        .SRAM_AA   (SRAM_AA),
        .SRAM_QA   (SRAM_QA),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Result SRAM contents and its port-A read behaviour (data one cycle after CENA low).
    logic [DW-1:0] mem [65536];
    always @(posedge clk) begin
        if (!SRAM_CENA) SRAM_QA <= mem[SRAM_AA];
    end

    typedef struct {
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-1:0] aa_log[$];
    logic [DW-1:0] acc_log[$];

    int            n_total = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            n0 = 0;
    int            first_valid_rel = -1;
    int            cena_cnt = 0;
    int            acc_cnt = 0;
    logic [AW-1:0] exp_addr = '0;
    bit            chk_en = 1'b0;
    bit            rnd_mode = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                      name, act, act, req, req, cyc);
    endtask

    // Compare process: every cycle of an active run, the stream must be the next
    // expected word, addresses must walk base, base+1, ... and the read-ahead
    // window (issued minus accepted) must stay within 2.
    always @(negedge clk) begin
        if (rst && chk_en) begin
            if (!SRAM_CENA) begin
                chk("aa_seq", SRAM_AA, exp_addr);
                aa_log.push_back(SRAM_AA);
                exp_addr++;
                cena_cnt++;
            end
            if (out_valid) begin
                if (first_valid_rel < 0) first_valid_rel = cyc - n0 + 1;
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("out_data", out_data, exp_q[0].dat);
                    chk("out_last", out_last, exp_q[0].last);
                end
                if (prev_stall) chk("stall_hold", out_data, prev_data);
                if (out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    acc_cnt++;
                    acc_log.push_back(out_data);
                end
            end
            chk("readahead_le2", (cena_cnt - acc_cnt) <= 2, 1);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic arm(input logic [AW-1:0] base, input int len, input bit rnd);
        exp_q.delete();
        aa_log.delete();
        acc_log.delete();
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.dat  = mem[AW'(base + i)];
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
        exp_addr        = base;
        cena_cnt        = 0;
        acc_cnt         = 0;
        prev_stall      = 1'b0;
        first_valid_rel = -1;
        rnd_mode        = rnd;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        length    = (AW+1)'(len);
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        chk_en    = 1'b1;
        @(posedge clk); #1;               // edge E0 has just sampled start
        start     = 1'b0;
        base_addr = ~base;                // must already be captured
        length    = '1;
        n0        = cyc;
    endtask

    task automatic run(input logic [AW-1:0] base, input int len, input bit rnd, output int done_rel);
        int busy_first, busy_last, n_done, rel;
        busy_first = -1;
        busy_last  = -1;
        n_done     = 0;
        done_rel   = -1;
        arm(base, len, rnd);
        for (int k = 0; k < 4 * len + 40; k++) begin
            @(negedge clk);
            rel = cyc - n0 + 1;
            if (busy) begin
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
            end
            if (done) begin
                n_done++;
                if (done_rel < 0) done_rel = rel;
            end
            if (done_rel >= 0 && rel >= done_rel + 2) break;
            @(posedge clk); #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk("done_seen", done_rel >= 0, 1);
        chk("done_pulses", n_done, 1);
        chk("busy_first", busy_first, 1);
        chk("busy_last", busy_last, done_rel - 1);
        chk("beats_accepted", acc_cnt, len);
        chk("cena_low_cycles", cena_cnt, len);
        chk("model_leftover", exp_q.size(), 0);
        if (len > 0) chk("first_valid_cycle", first_valid_rel, 3);
        else         chk("no_valid", first_valid_rel, -1);
        chk_en    = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cena"}, SRAM_CENA, 1);
        chk({tag, "_aa"}, SRAM_AA, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    initial begin
        int d;
        logic [AW-1:0] aa_want [4];

        for (int i = 0; i < 65536; i++) mem[i] = (32'(i) * 32'h0001_0003) ^ 32'hDEAD_0000;
        mem[0] = 32'd7;

        // Power-on reset values.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single word: SRAM[0]=7, done 3 cycles after the CENA-low cycle (cycle E0+4).
        run(16'd0, 1, 1'b0, d);
        chk("t1_done_cycle", d, 4);
        chk("t1_data", (acc_log.size() > 0) ? longint'(acc_log[0]) : -1, 7);

        // Long back-to-back burst: done at E0+1176+3.
        run(16'd4704, 1176, 1'b0, d);
        chk("t2_done_cycle", d, 1179);
        chk("t2_last_aa", (aa_log.size() > 0) ? longint'(aa_log[aa_log.size() - 1]) : -1, 5879);

        // Random backpressure.
        run(16'd100, 16, 1'b1, d);
        chk("t3_beats_logged", acc_log.size(), 16);

        // Empty range: done at E0+2, no SRAM access, no beats.
        run(16'd123, 0, 1'b0, d);
        chk("t4_done_cycle", d, 2);

        // Address wrap-around.
        aa_want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        run(16'hFFFE, 4, 1'b0, d);
        chk("t5_done_cycle", d, 7);
        for (int k = 0; k < 4; k++)
            chk("t5_wrap_aa", (k < aa_log.size()) ? longint'(aa_log[k]) : -1, aa_want[k]);
        chk("t5_wrap_data2", (acc_log.size() > 2) ? longint'(acc_log[2]) : -1, 7);

        // Reset during beat 5 of 16 (beat i is presented in cycle E0+3+i).
        arm(16'd0, 16, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cyc - n0 + 1 >= 8) break;
        end
        chk("t6_midrun_valid", out_valid, 1);
        #2;
        chk_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk_reset_outputs("abort");
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_after_release_valid", out_valid, 0);

        // Clean run after the abort: no leftover data.
        run(16'd0, 3, 1'b0, d);
        chk("t6_done_cycle", d, 6);
        chk("t6_first_data", (acc_log.size() > 0) ? longint'(acc_log[0]) : -1, 7);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
